// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the multiply sequencing front-end: operation
// encodings, controller states and datapath widths.
package mul_seq_ctrl_pkg;

  localparam int unsigned OPND_W      = 16;   // operand / product-half width
  localparam int unsigned PROD_W      = 32;   // full product width
  localparam int unsigned MUL_TIMEOUT = 64;   // default start-to-done limit

  typedef enum logic [1:0] {
    MUL_OP_U   = 2'b00,   // unsigned x unsigned
    MUL_OP_S   = 2'b01,   // signed x signed
    MUL_OP_SU  = 2'b10,   // signed A x unsigned B
    MUL_OP_RSV = 2'b11    // reserved, answered with an error
  } mul_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_FIX,
    ST_OUT
  } state_e;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Bundle of the three handshakes around the sequencer:
//   req_* : request from operand select (valid/ready)
//   mul_* : launch/complete exchange with the iterative multiplier core
//   rsp_* : result to register-file writeback (valid/ready)
// slave  : the sequencer's view; master : the surrounding environment's view.
interface mul_seq_ctrl_if;
  import mul_seq_ctrl_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [OPND_W-1:0] req_a;
  logic [OPND_W-1:0] req_b;

  logic              mul_start;
  logic [OPND_W-1:0] mul_a;
  logic [OPND_W-1:0] mul_b;
  logic [OPND_W-1:0] mul_hi;
  logic [OPND_W-1:0] mul_lo;
  logic              mul_done;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [OPND_W-1:0] rsp_hi;
  logic [OPND_W-1:0] rsp_lo;
  logic              rsp_z;
  logic              rsp_n;
  logic              rsp_v;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  mul_hi, mul_lo, mul_done,
    input  rsp_ready,
    output req_ready,
    output mul_start, mul_a, mul_b,
    output rsp_valid, rsp_hi, rsp_lo, rsp_z, rsp_n, rsp_v, rsp_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    output mul_hi, mul_lo, mul_done,
    output rsp_ready,
    input  req_ready,
    input  mul_start, mul_a, mul_b,
    input  rsp_valid, rsp_hi, rsp_lo, rsp_z, rsp_n, rsp_v, rsp_err
  );

endinterface

// File: rtl/mul_sign_fix.sv
// Conditional two's-complement negation, purely combinational.
// Used both to turn a signed operand into its magnitude (neg_i = sign bit)
// and to re-apply the result sign to the unsigned product.
// The most negative value maps onto itself (0x8000 -> 0x8000), which is
// exactly the magnitude the unsigned multiplier needs.
//   data_i : value in        neg_i : negate when high
//   data_o : value out
module mul_sign_fix
  import mul_seq_ctrl_pkg::*;
#(
  parameter int unsigned W = OPND_W
) (
  input  logic [W-1:0] data_i,
  input  logic         neg_i,
  output logic [W-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + W'(1)) : data_i;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencing front-end for the iterative 16x16 multiplier.
// Accepts one request, hands operand magnitudes to the core with a one-cycle
// start pulse, waits (bounded by TIMEOUT) for done, restores the result sign
// and presents product plus flags until the consumer takes it.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : req/mul/rsp handshakes (see mul_seq_ctrl_if)
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = MUL_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_seq_ctrl_if.slave  bus
);

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  mul_op_e             op_q, op_d;
  logic                neg_q, neg_d;
  logic [OPND_W-1:0]   a_q, a_d, b_q, b_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                z_q, z_d, n_q, n_d, v_q, v_d, err_q, err_d;

  mul_op_e             req_op;
  logic                sgn_a, sgn_b;
  logic [OPND_W-1:0]   mag_a, mag_b;
  logic [PROD_W-1:0]   prod_fix;

  assign req_op = mul_op_e'(bus.req_op);

  // A is signed for MULS and MULSU, B only for MULS.
  assign sgn_a = ((req_op == MUL_OP_S) || (req_op == MUL_OP_SU)) && bus.req_a[OPND_W-1];
  assign sgn_b = (req_op == MUL_OP_S) && bus.req_b[OPND_W-1];

  mul_sign_fix #(.W(OPND_W)) u_fix_a (.data_i(bus.req_a), .neg_i(sgn_a), .data_o(mag_a));
  mul_sign_fix #(.W(OPND_W)) u_fix_b (.data_i(bus.req_b), .neg_i(sgn_b), .data_o(mag_b));
  mul_sign_fix #(.W(PROD_W)) u_fix_p (.data_i(prod_q),    .neg_i(neg_q), .data_o(prod_fix));

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so that
    // branches which leave it untouched hold the register instead of
    // inferring a latch.
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    n_d     = n_q;
    v_d     = v_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_d  = req_op;
          neg_d = sgn_a ^ sgn_b;
          a_d   = mag_a;
          b_d   = mag_b;
          if (req_op == MUL_OP_RSV) begin
            // Reserved op: answer immediately, never launch the core.
            prod_d  = '0;
            z_d     = 1'b1;
            n_d     = 1'b0;
            v_d     = 1'b0;
            err_d   = 1'b1;
            state_d = ST_OUT;
          end else begin
            err_d   = 1'b0;
            state_d = ST_START;
          end
        end
      end

      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // done wins over the timeout in the last allowed cycle.
        if (bus.mul_done) begin
          prod_d  = {bus.mul_hi, bus.mul_lo};
          state_d = ST_FIX;
        end else if (cnt_q == CNT_LAST) begin
          prod_d  = '0;
          z_d     = 1'b1;
          n_d     = 1'b0;
          v_d     = 1'b0;
          err_d   = 1'b1;
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_FIX: begin
        prod_d = prod_fix;
        z_d    = (prod_fix == '0);
        n_d    = prod_fix[PROD_W-1];
        // Overflow: the result does not fit in a single 16-bit half.
        v_d    = (op_q == MUL_OP_U) ? (prod_fix[PROD_W-1:OPND_W] != '0)
                                    : (prod_fix[PROD_W-1:OPND_W] != {OPND_W{prod_fix[OPND_W-1]}});
        state_d = ST_OUT;
      end

      ST_OUT: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= MUL_OP_U;
      neg_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      n_q     <= n_d;
      v_q     <= v_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.mul_start = (state_q == ST_START);
  assign bus.rsp_valid = (state_q == ST_OUT);
  assign bus.mul_a     = a_q;
  assign bus.mul_b     = b_q;
  assign bus.rsp_hi    = prod_q[PROD_W-1:OPND_W];
  assign bus.rsp_lo    = prod_q[OPND_W-1:0];
  assign bus.rsp_z     = z_q;
  assign bus.rsp_n     = n_q;
  assign bus.rsp_v     = v_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl. The multiplier core is modelled by
// the bench (product of the magnitudes the DUT presents); expected responses
// come from plain integer arithmetic on the original signed/unsigned operands.
module tb_mul_seq_ctrl;
  import mul_seq_ctrl_pkg::*;

  localparam int TO = 64;

  typedef struct packed {
    logic [31:0] prod;
    logic        z;
    logic        n;
    logic        v;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks    = 0;
  int   failures  = 0;
  int   start_cnt = 0;

  mul_seq_ctrl_if bus_if ();

  mul_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // All time advances through here; mul_start pulses are counted on the way.
  task automatic step();
    @(negedge clk);
    if (bus_if.mul_start === 1'b1) start_cnt++;
  endtask

  function automatic exp_t ref_model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint va, vb, p;
    e = '0;
    if (op == 2'b11) begin
      e.z   = 1'b1;
      e.err = 1'b1;
      return e;
    end
    va     = (op != 2'b00) ? longint'($signed(a)) : longint'(a);
    vb     = (op == 2'b01) ? longint'($signed(b)) : longint'(b);
    p      = va * vb;
    e.prod = p[31:0];
    e.z    = (p == 0);
    e.n    = e.prod[31];
    e.v    = (op == 2'b00) ? (p > 65535) : (p < -32768 || p > 32767);
    return e;
  endfunction

  function automatic logic [15:0] mag16(input logic [15:0] x, input bit is_signed);
    longint v;
    v = is_signed ? longint'($signed(x)) : longint'(x);
    if (v < 0) v = -v;
    return v[15:0];
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic check_rsp(input string tag, input exp_t e);
    check({tag, "_valid"}, 32'(bus_if.rsp_valid), 32'd1);
    check({tag, "_prod"},  {bus_if.rsp_hi, bus_if.rsp_lo}, e.prod);
    check({tag, "_flags"}, 32'({bus_if.rsp_z, bus_if.rsp_n, bus_if.rsp_v, bus_if.rsp_err}),
                           32'({e.z, e.n, e.v, e.err}));
  endtask

  task automatic wait_rsp(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (bus_if.rsp_valid !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
    end
    check({tag, "_rsp_seen"}, 32'(bus_if.rsp_valid), 32'd1);
  endtask

  // Hold rsp_ready low for 'hold' cycles (response must stay frozen), then
  // complete the handshake and confirm the block is ready again.
  task automatic finish_rsp(input string tag, input exp_t e, input int hold);
    for (int i = 0; i < hold; i++) begin
      step();
      check_rsp({tag, "_hold"}, e);
      check({tag, "_hold_rdy"}, 32'(bus_if.req_ready), 32'd0);
    end
    bus_if.rsp_ready = 1'b1;
    step();
    bus_if.rsp_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(bus_if.rsp_valid), 32'd0);
    check({tag, "_done_rdy"},   32'(bus_if.req_ready), 32'd1);
  endtask

  // Present a request at a negedge; returns at the negedge after acceptance.
  task automatic send_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input string tag);
    check({tag, "_req_ready"}, 32'(bus_if.req_ready), 32'd1);
    bus_if.req_valid = 1'b1;
    bus_if.req_op    = op;
    bus_if.req_a     = a;
    bus_if.req_b     = b;
    step();
    bus_if.req_valid = 1'b0;
    bus_if.req_op    = 2'($urandom);
    bus_if.req_a     = 16'($urandom);
    bus_if.req_b     = 16'($urandom);
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int lat, input int hold, input string tag);
    exp_t        e;
    int          s0, cyc;
    logic [15:0] ma, mb;
    e  = ref_model(op, a, b);
    ma = mag16(a, op == 2'b01 || op == 2'b10);
    mb = mag16(b, op == 2'b01);
    s0 = start_cnt;
    send_req(op, a, b, tag);
    if (op == 2'b11) begin
      check({tag, "_rsv_lat"}, 32'(bus_if.rsp_valid), 32'd1);
    end else begin
      check({tag, "_start"}, 32'(bus_if.mul_start), 32'd1);
      check({tag, "_mul_a"}, 32'(bus_if.mul_a), 32'(ma));
      check({tag, "_mul_b"}, 32'(bus_if.mul_b), 32'(mb));
      for (int i = 0; i < lat; i++) begin
        step();
        check({tag, "_busy"}, 32'({bus_if.req_ready, bus_if.mul_start, bus_if.rsp_valid}), 32'd0);
      end
      {bus_if.mul_hi, bus_if.mul_lo} = 32'(bus_if.mul_a) * 32'(bus_if.mul_b);
      bus_if.mul_done = 1'b1;
      step();
      bus_if.mul_done = 1'b0;
      {bus_if.mul_hi, bus_if.mul_lo} = $urandom;
      check({tag, "_fix"}, 32'(bus_if.rsp_valid), 32'd0);
      step();
      check({tag, "_lat"}, 32'(bus_if.rsp_valid), 32'd1);
    end
    wait_rsp(tag, 8, cyc);
    check_rsp(tag, e);
    check({tag, "_starts"}, 32'(start_cnt - s0), (op == 2'b11) ? 32'd0 : 32'd1);
    if (op != 2'b11) check({tag, "_mag_hold"}, 32'({bus_if.mul_a, bus_if.mul_b}), 32'({ma, mb}));
    finish_rsp(tag, e, hold);
  endtask

  initial begin
    exp_t e;
    int   s0, cyc;
    bus_if.req_valid = 1'b0;
    bus_if.req_op    = 2'b00;
    bus_if.req_a     = '0;
    bus_if.req_b     = '0;
    bus_if.mul_hi    = '0;
    bus_if.mul_lo    = '0;
    bus_if.mul_done  = 1'b0;
    bus_if.rsp_ready = 1'b0;

    #1 rst_n = 1'b0;
    step();
    step();
    check("rst_ready", 32'(bus_if.req_ready), 32'd1);
    check("rst_ctl",   32'({bus_if.mul_start, bus_if.rsp_valid}), 32'd0);
    check("rst_mul_ab", {bus_if.mul_a, bus_if.mul_b}, 32'd0);
    check("rst_rsp",   {bus_if.rsp_hi, bus_if.rsp_lo}, 32'd0);
    check("rst_flags", 32'({bus_if.rsp_z, bus_if.rsp_n, bus_if.rsp_v, bus_if.rsp_err}), 32'd0);
    rst_n = 1'b1;
    step();

    // Directed vectors.
    run_txn(2'b00, 16'hFFFF, 16'hFFFF, 3, 0, "mulu_max");
    run_txn(2'b01, 16'hFFFD, 16'h0005, 1, 0, "muls_neg");
    run_txn(2'b01, 16'h8000, 16'h8000, 5, 1, "muls_min");
    run_txn(2'b10, 16'hFFFF, 16'h0002, 2, 0, "mulsu");
    run_txn(2'b00, 16'h0000, 16'h1234, 4, 0, "mulu_zero");
    run_txn(2'b11, 16'h1111, 16'h2222, 1, 0, "rsv");

    // Core never answers: error after the START cycle plus TIMEOUT WAIT
    // cycles, then the response is held for 10 cycles with rsp_ready low.
    s0 = start_cnt;
    send_req(2'b00, 16'h1234, 16'h0042, "tmo");
    check("tmo_start", 32'(bus_if.mul_start), 32'd1);
    wait_rsp("tmo", 200, cyc);
    check("tmo_cycles", 32'(cyc), 32'(TO + 1));
    e     = '0;
    e.z   = 1'b1;
    e.err = 1'b1;
    check_rsp("tmo", e);
    check("tmo_starts", 32'(start_cnt - s0), 32'd1);
    finish_rsp("tmo", e, 10);

    // Reset in the middle of WAIT, followed by a stray done.
    s0 = start_cnt;
    send_req(2'b00, 16'h0007, 16'h0009, "rstw");
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("rstw_ready", 32'(bus_if.req_ready), 32'd1);
    check("rstw_valid", 32'(bus_if.rsp_valid), 32'd0);
    check("rstw_mul_ab", {bus_if.mul_a, bus_if.mul_b}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    {bus_if.mul_hi, bus_if.mul_lo} = 32'hDEAD_BEEF;
    bus_if.mul_done = 1'b1;
    step();
    bus_if.mul_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rstw_idle", 32'({bus_if.req_ready, bus_if.rsp_valid}), 32'b10);
    end
    check("rstw_starts", 32'(start_cnt - s0), 32'd1);
    run_txn(2'b00, 16'h0003, 16'h0004, 2, 0, "post_rst");

    // Randomized traffic, back-to-back.
    for (int i = 0; i < 40; i++) begin
      run_txn(2'($urandom_range(0, 3)), pick(), pick(), $urandom_range(1, 12),
              $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencing front-end for the iterative 16x16 ALU multiplier. Accepts multiply requests from the execute stage over a valid/ready handshake and converts signed operands to magnitudes. Launches the multiplier with a one-cycle start pulse, waits for its done pulse, applies sign correction to the 32-bit product, and presents the result with flags over a second valid/ready handshake. Sits between ALU operand select (upstream) and the multiplier core plus register-file writeback (downstream).

## Interface
- TIMEOUT, 64: max cycles from start pulse to done before the request is aborted with error.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_op  in  2  00 MULU, 01 MULS (signed x signed), 10 MULSU (signed A x unsigned B), 11 reserved.
- req_a, req_b  in  16  operands.
- mul_start  out  1  one-cycle launch pulse to multiplier.
- mul_a, mul_b  out  16  magnitude operands, stable from START until the next request.
- mul_hi, mul_lo  in  16  multiplier product halves; sampled only on mul_done.
- mul_done  in  1  single-cycle completion pulse from multiplier.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts.
- rsp_hi, rsp_lo  out  16  signed/unsigned 32-bit product.
- rsp_z, rsp_n, rsp_v, rsp_err  out  1  product zero, bit31, high half not extension of low, abort/reserved.

## Operation
- States: IDLE, START, WAIT, FIX, OUT.
- IDLE: req_ready=1. On req_valid, latch op, compute neg = sign-of-result (MULS: a15^b15; MULSU: a15; MULU: 0), latch |a|, |b| (unsigned ops pass through; 0x8000 magnitude is 0x8000). Reserved op: latch err=1, go OUT with product 0, no launch. Otherwise go START.
- START: mul_start=1 for exactly this cycle; clear timeout counter; go WAIT.
- WAIT: count cycles. On mul_done, capture {mul_hi,mul_lo}, go FIX. If count reaches TIMEOUT-1 without done, set err, product 0, go OUT. A mul_done seen in any state other than WAIT is ignored.
- FIX: if neg, product = two's complement of the 32-bit capture (wraps modulo 2^32), else unchanged. Compute flags: z = product==0; n = product[31]; v = MULU ? hi!=0 : hi != {16{lo[15]}}. Go OUT.
- OUT: rsp_valid=1, outputs held stable until rsp_valid&&rsp_ready, then go IDLE. err responses have z=1, n=0, v=0.

## Timing
- Reset: state IDLE; req_ready=1; mul_start=0; rsp_valid=0; mul_a, mul_b, rsp_hi, rsp_lo=0; all flags 0; counter 0.
- Accept edge -> START next cycle -> mul_start pulse; result valid 2 cycles after the mul_done cycle (FIX, then OUT). Total latency = multiplier latency + 3 cycles with rsp_ready held high.
- Reserved op: rsp_valid asserted the cycle after acceptance.
- One request in flight; req_ready low from acceptance until the response handshake completes. Back-to-back: a new request can be accepted the cycle after the rsp handshake.
- rsp_ready held low: OUT persists indefinitely, outputs frozen.
- Reset asserted mid-WAIT: returns to IDLE immediately; a subsequent stray mul_done is ignored. The multiplier must be reset by the same reset (inverted to active-high at its port).

## Structure
- Shared package: op encodings (MUL_OP_U, MUL_OP_S, MUL_OP_SU, MUL_OP_RSV), state enum, product width constant 32.
- One sub-module, mul_sign_fix: combinational magnitude extraction and conditional 32-bit negation; instantiated for the operand path and for the product path.
- Timeout counter width clog2(TIMEOUT).

## Test plan
- MULU 0xFFFF x 0xFFFF -> rsp 0xFFFE_0001, z=0 n=1 v=1 err=0; exactly one mul_start pulse.
- MULS 0xFFFD (-3) x 0x0005 -> 0xFFFF_FFF1, n=1 v=0; MULS 0x8000 x 0x8000 -> 0x4000_0000, v=1.
- MULSU 0xFFFF x 0x0002 -> 0xFFFF_FFFE, n=1 v=0; MULU 0x0000 x 0x1234 -> 0, z=1.
- Op 11 -> rsp_err=1 one cycle after accept, no mul_start, product 0.
- mul_done tied low -> err response after TIMEOUT cycles in WAIT; rsp_ready low for 10 cycles -> outputs stable, req_ready stays 0.
- Reset pulse during WAIT, then stray mul_done -> block stays IDLE, rsp_valid=0; next MULU 3 x 4 -> 0x0000_000C.
